// File: rtl/sdram_rd_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_rd_port_arbiter
// Description : Shares one SDRAM read port between two burst requesters.
//               r0 is the real-time VGA line refill (high priority) and r1 is
//               the background image resize engine. One burst runs at a time
//               with a single word outstanding. Returned words are routed to
//               the burst owner. A starvation counter guarantees r1 a grant
//               after STARVE_LIM consecutive r0 bursts. A per-word watchdog
//               aborts the burst if read data never returns.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               rN_req/addr/len     - burst request, start address, length
//               rN_gnt              - high for the whole burst owned by N
//               rN_data/valid       - returned word and its 1-cycle strobe
//               rN_done             - 1-cycle end-of-burst strobe
//               mem_rd_req/addr/ack - read command handshake to controller
//               mem_rd_data/valid   - read data from controller
//               busy                - a burst is in progress
//               timeout_err         - sticky read-data timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_rd_port_arbiter #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 10,
    parameter int STARVE_LIM = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [LEN_W-1:0]  r0_len,
    output logic              r0_gnt,
    output logic [DATA_W-1:0] r0_data,
    output logic              r0_valid,
    output logic              r0_done,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [LEN_W-1:0]  r1_len,
    output logic              r1_gnt,
    output logic [DATA_W-1:0] r1_data,
    output logic              r1_valid,
    output logic              r1_done,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              busy,
    output logic              timeout_err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam int c_SC_W  = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    // Timer only needs to reach TIMEOUT-1: the abort fires on that cycle.
    localparam int c_TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [c_SC_W-1:0]  c_SC_LIM   = c_SC_W'(STARVE_LIM);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);
    localparam logic [LEN_W-1:0]   c_LEN_ONE  = LEN_W'(1);

    logic [1:0]         r_state;
    logic               r_owner;      // 0 = r0, 1 = r1
    logic               r_hold;       // one-cycle command gap after a same-cycle ack+valid
    logic [ADDR_W-1:0]  r_cur_addr;
    logic [LEN_W-1:0]   r_remaining;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_SC_W-1:0]  r_starve;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic               r_timeout_err;

    logic               w_grant_r1;
    logic [LEN_W-1:0]   w_req_len;
    logic [LEN_W-1:0]   w_first_len;
    logic               w_last_word;
    logic               w_take_word;

    // r1 wins when it is the only requester, or when r0 has used up its
    // allowance of consecutive bursts while r1 was waiting.
    assign w_grant_r1  = r1_req && (!r0_req || (r_starve == c_SC_LIM));
    assign w_req_len   = w_grant_r1 ? r1_len : r0_len;
    assign w_first_len = (w_req_len == '0) ? c_LEN_ONE : w_req_len;
    assign w_last_word = (r_remaining == c_LEN_ONE);

    // A word is taken either on a same-cycle ack+valid while issuing, or on
    // valid while waiting. Valid at any other time is stray and dropped.
    assign w_take_word = ((r_state == c_ISSUE) && !r_hold && mem_rd_ack && mem_rd_valid) ||
                         ((r_state == c_WAIT) && mem_rd_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_owner       <= 1'b0;
            r_hold        <= 1'b0;
            r_cur_addr    <= '0;
            r_remaining   <= '0;
            r_timer       <= '0;
            r_starve      <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            if (w_take_word) begin
                r_data      <= mem_rd_data;
                r_valid     <= 1'b1;
                r_cur_addr  <= r_cur_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (!r1_req) begin
                        r_starve <= '0;
                    end
                    if (r0_req || r1_req) begin
                        r_owner     <= w_grant_r1;
                        r_cur_addr  <= w_grant_r1 ? r1_addr : r0_addr;
                        r_remaining <= w_first_len;
                        r_hold      <= 1'b0;
                        r_state     <= c_ISSUE;
                        if (w_grant_r1) begin
                            r_starve <= '0;
                        end else if (r1_req && (r_starve != c_SC_LIM)) begin
                            r_starve <= r_starve + 1'b1;
                        end
                    end
                end

                c_ISSUE: begin
                    if (r_hold) begin
                        r_hold <= 1'b0;
                    end else if (mem_rd_ack) begin
                        if (mem_rd_valid) begin
                            if (w_last_word) begin
                                r_state <= c_DONE;
                            end else begin
                                r_hold <= 1'b1;
                            end
                        end else begin
                            r_timer <= '0;
                            r_state <= c_WAIT;
                        end
                    end
                end

                c_WAIT: begin
                    if (mem_rd_valid) begin
                        r_state <= w_last_word ? c_DONE : c_ISSUE;
                    end else if (r_timer == c_TMR_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= c_DONE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != c_IDLE);
    assign r0_gnt      = busy && !r_owner;
    assign r1_gnt      = busy && r_owner;
    assign r0_valid    = r_valid && !r_owner;
    assign r1_valid    = r_valid && r_owner;
    assign r0_data     = r_owner ? '0 : r_data;
    assign r1_data     = r_owner ? r_data : '0;
    assign r0_done     = (r_state == c_DONE) && !r_owner;
    assign r1_done     = (r_state == c_DONE) && r_owner;
    assign mem_rd_req  = (r_state == c_ISSUE) && !r_hold;
    assign mem_rd_addr = r_cur_addr;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
